// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: FSM state codes and named phase indices
// used by the downstream fetch/decode/alu/register blocks.
package phase_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

  localparam int PH_FETCH     = 0;
  localparam int PH_DECODE    = 1;
  localparam int PH_SEL1      = 2;
  localparam int PH_ALU1      = 3;
  localparam int PH_LOAD1     = 4;
  localparam int PH_SEL2      = 5;
  localparam int PH_ALU2      = 6;
  localparam int PH_LOAD2     = 7;
  localparam int PH_SEL3      = 8;
  localparam int PH_ALU3      = 9;
  localparam int PH_LOAD3     = 10;
  localparam int PH_MEM_ADDR  = 11;
  localparam int PH_MEM_DATA  = 12;
  localparam int PH_WRITEBACK = 13;
  localparam int PH_EIP_UPD   = 14;

endpackage

// File: rtl/phase_sequencer_pulse_edge_detect.sv
// Turns a level input (debug step button) into a single-cycle pulse on its rising edge.
// The previous level is registered every cycle, so a held level yields one pulse only.
module pulse_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q_reg <= 1'b0;
    end else begin
      level_q_reg <= level;
    end
  end

  assign rise = level & ~level_q_reg;

endmodule

// File: rtl/phase_sequencer.sv
// One-hot phase-enable sequencer for the CPU core: variable-length instruction cycles,
// stall hold, single-step halt and a retired-instruction counter, all on one clock.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASES = 15,
  parameter int IDX_W      = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [IDX_W-1:0]      last_phase,
  input  logic                  step_mode,
  input  logic                  step,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  cycle_start,
  output logic                  cycle_end,
  output logic                  halted,
  output logic [CNT_W-1:0]      retire_cnt
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_PHASES - 1);

  seq_state_t       state_reg;
  logic [IDX_W-1:0] phase_idx_reg;
  logic [CNT_W-1:0] retire_cnt_reg;
  logic             step_rise;
  logic             run_active;
  logic             fire;
  logic [IDX_W-1:0] eff_last;

  pulse_edge_detect u_step_edge (
    .clk   (clk),
    .reset (reset),
    .level (step),
    .rise  (step_rise)
  );

  // Enables decode straight from the registers so a phase fires in the same cycle its index is held.
  assign run_active = (state_reg == ST_RUN) && !stall && !reset;

  generate
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase_dec
      assign phase_en[gi] = run_active && (phase_idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign fire        = |phase_en;
  assign eff_last    = (last_phase > MAX_IDX) ? MAX_IDX : last_phase;
  assign cycle_end   = fire && (phase_idx_reg >= eff_last);
  assign cycle_start = phase_en[PH_FETCH];
  assign halted      = (state_reg == ST_HALT);
  assign phase_idx   = phase_idx_reg;
  assign retire_cnt  = retire_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      phase_idx_reg  <= '0;
      retire_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          phase_idx_reg <= '0;
          state_reg     <= step_mode ? ST_HALT : ST_RUN;
        end
        ST_RUN: begin
          // A stalled cycle has fire=0, so the index is simply held until the phase actually fires.
          if (fire) begin
            if (cycle_end) begin
              phase_idx_reg  <= '0;
              retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
              state_reg      <= step_mode ? ST_HALT : ST_RUN;
            end else begin
              phase_idx_reg <= phase_idx_reg + IDX_W'(1);
            end
          end
        end
        ST_HALT: begin
          if (step_rise) begin
            phase_idx_reg <= '0;
            state_reg     <= ST_RUN;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          phase_idx_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer: free run, variable length, stall,
// single-step, mid-cycle reset and counter wrap (second instance with a 4-bit counter).
module tb_phase_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, step_mode, step;
  logic [3:0]  last_phase;

  logic [14:0] phase_en,  phase_en4;
  logic [3:0]  phase_idx, phase_idx4;
  logic        cycle_start, cycle_end, halted;
  logic        cycle_start4, cycle_end4, halted4;
  logic [31:0] retire_cnt;
  logic [3:0]  retire_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  phase_sequencer #(.NUM_PHASES(15), .IDX_W(4), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .last_phase  (last_phase),
    .step_mode   (step_mode),
    .step        (step),
    .phase_en    (phase_en),
    .phase_idx   (phase_idx),
    .cycle_start (cycle_start),
    .cycle_end   (cycle_end),
    .halted      (halted),
    .retire_cnt  (retire_cnt)
  );

  phase_sequencer #(.NUM_PHASES(15), .IDX_W(4), .CNT_W(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .last_phase  (last_phase),
    .step_mode   (step_mode),
    .step        (step),
    .phase_en    (phase_en4),
    .phase_idx   (phase_idx4),
    .cycle_start (cycle_start4),
    .cycle_end   (cycle_end4),
    .halted      (halted4),
    .retire_cnt  (retire_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; step_mode = 1'b0; step = 1'b0; last_phase = 4'd14;
    #1;
    chk("rst_phase_en", 32'(phase_en), 32'h0);
    chk("rst_cycle_end", 32'(cycle_end), 32'h0);
    repeat (3) tick();
    chk("rst_idx", 32'(phase_idx), 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cycle_start", 32'(cycle_start), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_phase_en", 32'(phase_en), 32'h0);
    tick();

    // Free run, full 15-phase cycles
    $display("step 1: free run last_phase=14");
    for (int k = 0; k < 45; k++) begin
      chk("t1_phase_en", 32'(phase_en), 32'd1 << (k % 15));
      chk("t1_cycle_end", 32'(cycle_end), 32'((k % 15) == 14));
      chk("t1_cnt", retire_cnt, 32'(k / 15));
      tick();
    end
    chk("t1_cnt_final", retire_cnt, 32'd3);
    chk("t1_restart", 32'(phase_en), 32'h1);

    // Variable cycle length
    $display("step 2: last_phase=3, 0, clamp, lowered mid-cycle");
    last_phase = 4'd3;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t2_len4_phase_en", 32'(phase_en), 32'd1 << (k % 4));
      chk("t2_len4_cycle_end", 32'(cycle_end), 32'((k % 4) == 3));
      tick();
    end
    chk("t2_len4_cnt", retire_cnt, 32'd5);
    last_phase = 4'd0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_len1_phase_en", 32'(phase_en), 32'h1);
      chk("t2_len1_start", 32'(cycle_start), 32'd1);
      chk("t2_len1_end", 32'(cycle_end), 32'd1);
      tick();
    end
    chk("t2_len1_cnt", retire_cnt, 32'd9);
    last_phase = 4'd15;
    #1;
    for (int k = 0; k < 15; k++) begin
      chk("t2_clamp_phase_en", 32'(phase_en), 32'd1 << k);
      chk("t2_clamp_cycle_end", 32'(cycle_end), 32'(k == 14));
      tick();
    end
    chk("t2_clamp_cnt", retire_cnt, 32'd10);
    last_phase = 4'd14;
    repeat (8) tick();
    chk("t2_lower_idx", 32'(phase_idx), 32'd8);
    last_phase = 4'd2;
    #1;
    chk("t2_lower_end", 32'(cycle_end), 32'd1);
    chk("t2_lower_phase_en", 32'(phase_en), 32'h100);
    tick();
    chk("t2_lower_idx0", 32'(phase_idx), 32'd0);
    chk("t2_lower_cnt", retire_cnt, 32'd11);
    last_phase = 4'd14;

    // Stall held 5 clocks at phase 6
    $display("step 3: stall at phase 6");
    repeat (6) tick();
    stall = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_stall_phase_en", 32'(phase_en), 32'h0);
      chk("t3_stall_idx", 32'(phase_idx), 32'd6);
      chk("t3_stall_end", 32'(cycle_end), 32'd0);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("t3_resume_6", 32'(phase_en), 32'h40);
    tick();
    chk("t3_resume_7", 32'(phase_en), 32'h80);
    repeat (7) tick();
    chk("t3_last_end", 32'(cycle_end), 32'd1);
    tick();
    chk("t3_len20_start", 32'(cycle_start), 32'd1);
    chk("t3_cnt", retire_cnt, 32'd12);

    // Step mode entered during RUN: current cycle completes, then halt
    $display("step 4: single-step mode");
    step_mode = 1'b1;
    #1;
    for (int k = 0; k < 15; k++) begin
      chk("t4_finish_phase_en", 32'(phase_en), 32'd1 << k);
      chk("t4_finish_halted", 32'(halted), 32'd0);
      tick();
    end
    chk("t4_halt_after_cycle", 32'(halted), 32'd1);
    chk("t4_halt_phase_en", 32'(phase_en), 32'h0);
    chk("t4_halt_cnt", retire_cnt, 32'd13);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t4_idle_halted", 32'(halted), 32'd0);
    tick();
    chk("t4_reset_halted", 32'(halted), 32'd1);
    chk("t4_reset_phase_en", 32'(phase_en), 32'h0);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk("t4_stall_in_halt", 32'(halted), 32'd1);
    step = 1'b1;
    #1;
    chk("t4_step_same_clk", 32'(phase_en), 32'h0);
    tick();
    for (int k = 0; k < 15; k++) begin
      if (k == 9) step = 1'b0;
      chk("t4_step1_phase_en", 32'(phase_en), 32'd1 << k);
      chk("t4_step1_halted", 32'(halted), 32'd0);
      tick();
    end
    chk("t4_step1_halted_end", 32'(halted), 32'd1);
    chk("t4_step1_cnt", retire_cnt, 32'd1);
    repeat (3) tick();
    chk("t4_held_no_repeat", 32'(halted), 32'd1);
    chk("t4_held_cnt", retire_cnt, 32'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k == 5) step = 1'b1;
      if (k == 7) step = 1'b0;
      chk("t4_step2_phase_en", 32'(phase_en), 32'd1 << k);
      tick();
    end
    chk("t4_step2_halted", 32'(halted), 32'd1);
    chk("t4_step2_cnt", retire_cnt, 32'd2);
    repeat (2) tick();
    chk("t4_run_edge_ignored", 32'(halted), 32'd1);

    // Reset mid-cycle at phase 9
    $display("step 5: reset at phase 9");
    step_mode = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (9) tick();
    chk("t5_idx9", 32'(phase_idx), 32'd9);
    reset = 1'b1;
    #1;
    chk("t5_rst_phase_en", 32'(phase_en), 32'h0);
    chk("t5_rst_cycle_end", 32'(cycle_end), 32'd0);
    tick();
    chk("t5_rst_idx", 32'(phase_idx), 32'd0);
    chk("t5_rst_cnt", retire_cnt, 32'd0);
    chk("t5_rst_phase_en2", 32'(phase_en), 32'h0);
    reset = 1'b0;
    #1;
    chk("t5_idle_phase_en", 32'(phase_en), 32'h0);
    tick();
    chk("t5_restart_phase_en", 32'(phase_en), 32'h1);

    // Counter wrap on the 4-bit instance
    $display("step 6: retire counter wrap");
    last_phase = 4'd0;
    #1;
    repeat (15) tick();
    chk("t6_cnt4_15", 32'(retire_cnt4), 32'd15);
    tick();
    chk("t6_cnt4_wrap", 32'(retire_cnt4), 32'd0);
    chk("t6_cnt32_16", retire_cnt, 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
